// File: rtl/decode_capture_stage.sv
`default_nettype none
// ============================================================================
// decode_capture_stage
// Two-entry skid FIFO between decode and the issue info table, tracking
// per-wavefront "accepted, not yet issued" bits and their population count.
// Optional flush support: define DECODE_CAPTURE_FLUSH_EN.
// Revision: 1.0
// ============================================================================

`ifndef WF_ID_LENGTH
`define WF_ID_LENGTH 6
`endif
`ifndef ISSUE_INSTR_INFO_LENGTH
`define ISSUE_INSTR_INFO_LENGTH 16
`endif
`ifndef WF_PER_CU
`define WF_PER_CU 40
`endif

module decode_capture_stage (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                decode_valid,
  input  logic [`WF_ID_LENGTH-1:0]            decode_wfid,
  input  logic [`ISSUE_INSTR_INFO_LENGTH-1:0] decode_instr_info,
  output logic                                decode_ready,
  input  logic                                tbl_wr_stall,
  output logic                                f_decode_valid,
  output logic [`WF_ID_LENGTH-1:0]            f_decode_wfid,
  output logic [`ISSUE_INSTR_INFO_LENGTH-1:0] decode_wr_data,
  input  logic                                issue_valid,
  input  logic [`WF_ID_LENGTH-1:0]            issue_wfid,
`ifdef DECODE_CAPTURE_FLUSH_EN
  input  logic                                flush_valid,
  input  logic [`WF_ID_LENGTH-1:0]            flush_wfid,
`endif
  output logic [`WF_PER_CU-1:0]               wf_instr_pending,
  output logic [5:0]                          pending_count
);

  localparam logic [`WF_ID_LENGTH-1:0] c_wf_last = `WF_ID_LENGTH'(`WF_PER_CU - 1);

  logic [1:0]                          r_valid;
  logic [`WF_ID_LENGTH-1:0]            r_wfid [2];
  logic [`ISSUE_INSTR_INFO_LENGTH-1:0] r_info [2];
  logic [`WF_PER_CU-1:0]               r_pending;
  logic [5:0]                          r_count;

  logic                                w_flush_valid;
  logic [`WF_ID_LENGTH-1:0]            w_flush_wfid;

`ifdef DECODE_CAPTURE_FLUSH_EN
  assign w_flush_valid = flush_valid;
  assign w_flush_wfid  = flush_wfid;
`else
  assign w_flush_valid = 1'b0;
  assign w_flush_wfid  = '0;
`endif

  logic [1:0] w_occupancy;
  logic       w_decode_ok;
  logic       w_issue_ok;
  logic       w_flush_ok;
  logic       w_flush_head;
  logic       w_flush_tail;
  logic       w_flush_hits_decode;
  logic       w_push;
  logic       w_pop;
  logic       w_issue_eff;
  logic       w_flush_eff;

  assign w_occupancy  = {1'b0, r_valid[0]} + {1'b0, r_valid[1]};
  assign w_decode_ok  = (decode_wfid <= c_wf_last);
  assign w_issue_ok   = (issue_wfid <= c_wf_last);
  assign w_flush_ok   = (w_flush_wfid <= c_wf_last);
  assign w_flush_head = w_flush_valid && r_valid[0] && (r_wfid[0] == w_flush_wfid);
  assign w_flush_tail = w_flush_valid && r_valid[1] && (r_wfid[1] == w_flush_wfid);
  assign w_flush_hits_decode = w_flush_valid && (w_flush_wfid == decode_wfid);

  // Ready looks only at registered state so a same-cycle issue cannot open it.
  assign decode_ready = rst && w_decode_ok && (w_occupancy < 2'd2) &&
                        !r_pending[decode_wfid];

  assign w_push = decode_valid && decode_ready && !w_flush_hits_decode;

  assign f_decode_valid = rst && r_valid[0] && !tbl_wr_stall && !w_flush_head;
  assign f_decode_wfid  = rst ? r_wfid[0] : '0;
  assign decode_wr_data = rst ? r_info[0] : '0;
  assign w_pop          = f_decode_valid;

  assign w_issue_eff = issue_valid && w_issue_ok && r_pending[issue_wfid];
  assign w_flush_eff = w_flush_valid && w_flush_ok && r_pending[w_flush_wfid] &&
                       !(w_issue_eff && (issue_wfid == w_flush_wfid));

  logic [1:0]                          w_valid_next;
  logic [`WF_ID_LENGTH-1:0]            w_wfid_next [2];
  logic [`ISSUE_INSTR_INFO_LENGTH-1:0] w_info_next [2];
  logic [1:0]                          w_n;
  logic [`WF_PER_CU-1:0]               w_pending_next;
  logic [5:0]                          w_count_next;

  always_comb begin
    w_wfid_next[0] = r_wfid[0];
    w_wfid_next[1] = r_wfid[1];
    w_info_next[0] = r_info[0];
    w_info_next[1] = r_info[1];
    w_n            = 2'd0;

    // Compact surviving entries toward the head, then pop, then append.
    if (r_valid[0] && !w_flush_head) begin
      w_n = (r_valid[1] && !w_flush_tail) ? 2'd2 : 2'd1;
    end else if (r_valid[1] && !w_flush_tail) begin
      w_wfid_next[0] = r_wfid[1];
      w_info_next[0] = r_info[1];
      w_n            = 2'd1;
    end

    if (w_pop) begin
      w_wfid_next[0] = w_wfid_next[1];
      w_info_next[0] = w_info_next[1];
      w_n            = w_n - 2'd1;
    end

    if (w_push) begin
      if (w_n == 2'd0) begin
        w_wfid_next[0] = decode_wfid;
        w_info_next[0] = decode_instr_info;
      end else begin
        w_wfid_next[1] = decode_wfid;
        w_info_next[1] = decode_instr_info;
      end
      w_n = w_n + 2'd1;
    end

    case (w_n)
      2'd0:    w_valid_next = 2'b00;
      2'd1:    w_valid_next = 2'b01;
      default: w_valid_next = 2'b11;
    endcase
  end

  always_comb begin
    w_pending_next = r_pending;
    if (w_issue_eff) w_pending_next[issue_wfid] = 1'b0;
    if (w_flush_valid && w_flush_ok) w_pending_next[w_flush_wfid] = 1'b0;
    if (w_push) w_pending_next[decode_wfid] = 1'b1;
    w_count_next = r_count + 6'(w_push) - 6'(w_issue_eff) - 6'(w_flush_eff);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid   <= 2'b00;
      r_wfid[0] <= '0;
      r_wfid[1] <= '0;
      r_info[0] <= '0;
      r_info[1] <= '0;
      r_pending <= '0;
      r_count   <= '0;
    end else begin
      r_valid   <= w_valid_next;
      r_wfid[0] <= w_wfid_next[0];
      r_wfid[1] <= w_wfid_next[1];
      r_info[0] <= w_info_next[0];
      r_info[1] <= w_info_next[1];
      r_pending <= w_pending_next;
      r_count   <= w_count_next;
    end
  end

  assign wf_instr_pending = r_pending;
  assign pending_count    = r_count;

endmodule

`default_nettype wire

// File: tb/tb_decode_capture_stage.sv
`default_nettype none
// ============================================================================
// tb_decode_capture_stage
// Directed self-checking bench for decode_capture_stage.
// Revision: 1.0
// ============================================================================

`ifndef WF_ID_LENGTH
`define WF_ID_LENGTH 6
`endif
`ifndef ISSUE_INSTR_INFO_LENGTH
`define ISSUE_INSTR_INFO_LENGTH 16
`endif
`ifndef WF_PER_CU
`define WF_PER_CU 40
`endif

module tb_decode_capture_stage;

  logic                                clk;
  logic                                rst;
  logic                                decode_valid;
  logic [`WF_ID_LENGTH-1:0]            decode_wfid;
  logic [`ISSUE_INSTR_INFO_LENGTH-1:0] decode_instr_info;
  logic                                decode_ready;
  logic                                tbl_wr_stall;
  logic                                f_decode_valid;
  logic [`WF_ID_LENGTH-1:0]            f_decode_wfid;
  logic [`ISSUE_INSTR_INFO_LENGTH-1:0] decode_wr_data;
  logic                                issue_valid;
  logic [`WF_ID_LENGTH-1:0]            issue_wfid;
`ifdef DECODE_CAPTURE_FLUSH_EN
  logic                                flush_valid;
  logic [`WF_ID_LENGTH-1:0]            flush_wfid;
`endif
  logic [`WF_PER_CU-1:0]               wf_instr_pending;
  logic [5:0]                          pending_count;

  int n_checks = 0;
  int n_errors = 0;

  decode_capture_stage u_dut (
    .clk               (clk),
    .rst               (rst),
    .decode_valid      (decode_valid),
    .decode_wfid       (decode_wfid),
    .decode_instr_info (decode_instr_info),
    .decode_ready      (decode_ready),
    .tbl_wr_stall      (tbl_wr_stall),
    .f_decode_valid    (f_decode_valid),
    .f_decode_wfid     (f_decode_wfid),
    .decode_wr_data    (decode_wr_data),
    .issue_valid       (issue_valid),
    .issue_wfid        (issue_wfid),
`ifdef DECODE_CAPTURE_FLUSH_EN
    .flush_valid       (flush_valid),
    .flush_wfid        (flush_wfid),
`endif
    .wf_instr_pending  (wf_instr_pending),
    .pending_count     (pending_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the edge; checks happen 2ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic offer(input int wfid, input int info);
    decode_valid      = 1'b1;
    decode_wfid       = `WF_ID_LENGTH'(wfid);
    decode_instr_info = `ISSUE_INSTR_INFO_LENGTH'(info);
  endtask

  task automatic idle();
    decode_valid = 1'b0;
    issue_valid  = 1'b0;
`ifdef DECODE_CAPTURE_FLUSH_EN
    flush_valid  = 1'b0;
`endif
  endtask

  task automatic issue_all();
    for (int i = 0; i < `WF_PER_CU; i++) begin
      tick();
      issue_valid = 1'b1;
      issue_wfid  = `WF_ID_LENGTH'(i);
    end
    tick();
    issue_valid = 1'b0;
  endtask

  initial begin
    rst               = 1'b0;
    decode_valid      = 1'b1;
    decode_wfid       = `WF_ID_LENGTH'(3);
    decode_instr_info = `ISSUE_INSTR_INFO_LENGTH'('h111);
    tbl_wr_stall      = 1'b0;
    issue_valid       = 1'b0;
    issue_wfid        = '0;
`ifdef DECODE_CAPTURE_FLUSH_EN
    flush_valid       = 1'b0;
    flush_wfid        = '0;
`endif

    // Reset held two cycles with decode offering.
    for (int c = 0; c < 2; c++) begin
      tick(); settle();
      check("rst_ready", 64'(decode_ready), 0);
      check("rst_fvalid", 64'(f_decode_valid), 0);
      check("rst_count", 64'(pending_count), 0);
      check("rst_fwfid", 64'(f_decode_wfid), 0);
      check("rst_wrdata", 64'(decode_wr_data), 0);
    end

    // Release reset: no write strobe in the first cycle.
    tick();
    rst = 1'b1;
    idle();
    settle();
    check("rel_fvalid", 64'(f_decode_valid), 0);
    check("rel_ready", 64'(decode_ready), 1);

    // Basic accept, one-cycle latency.
    tick();
    offer(5, 'hABC);
    settle();
    check("acc5_ready", 64'(decode_ready), 1);
    tick();
    idle();
    settle();
    check("acc5_fvalid", 64'(f_decode_valid), 1);
    check("acc5_fwfid", 64'(f_decode_wfid), 5);
    check("acc5_data", 64'(decode_wr_data), 'hABC);
    check("acc5_pend", 64'(wf_instr_pending[5]), 1);
    check("acc5_count", 64'(pending_count), 1);
    tick(); settle();
    check("acc5_popped", 64'(f_decode_valid), 0);

    // Stall fills the FIFO; third offer is refused and held.
    tick();
    tbl_wr_stall = 1'b1;
    offer(1, 'h101);
    settle();
    check("stl_ready1", 64'(decode_ready), 1);
    tick();
    offer(2, 'h202);
    settle();
    check("stl_ready2", 64'(decode_ready), 1);
    check("stl_fvalid", 64'(f_decode_valid), 0);
    check("stl_fwfid_a", 64'(f_decode_wfid), 1);
    tick();
    offer(3, 'h303);
    settle();
    check("stl_full", 64'(decode_ready), 0);
    check("stl_count", 64'(pending_count), 3);
    tick(); settle();
    check("stl_hold", 64'(decode_ready), 0);
    check("stl_fwfid_b", 64'(f_decode_wfid), 1);
    check("stl_data_b", 64'(decode_wr_data), 'h101);
    tick();
    tbl_wr_stall = 1'b0;
    idle();
    settle();
    check("drain1_v", 64'(f_decode_valid), 1);
    check("drain1_w", 64'(f_decode_wfid), 1);
    check("drain1_d", 64'(decode_wr_data), 'h101);
    tick(); settle();
    check("drain2_v", 64'(f_decode_valid), 1);
    check("drain2_w", 64'(f_decode_wfid), 2);
    check("drain2_d", 64'(decode_wr_data), 'h202);
    tick(); settle();
    check("drain_empty", 64'(f_decode_valid), 0);

    // Issue of a non-pending wfid is ignored; issue of a pending one clears.
    issue_valid = 1'b1;
    issue_wfid  = `WF_ID_LENGTH'(9);
    tick();
    issue_wfid  = `WF_ID_LENGTH'(5);
    settle();
    check("iss_nonpend", 64'(pending_count), 3);
    tick();
    issue_valid = 1'b0;
    settle();
    check("iss5_count", 64'(pending_count), 2);
    check("iss5_pend", 64'(wf_instr_pending[5]), 0);

    // Same-cycle issue and re-offer of wfid 7.
    offer(7, 'h777);
    tick();
    idle();
    tick(); settle();
    check("w7_count", 64'(pending_count), 3);
    offer(7, 'h778);
    issue_valid = 1'b1;
    issue_wfid  = `WF_ID_LENGTH'(7);
    settle();
    check("w7_reject", 64'(decode_ready), 0);
    tick();
    issue_valid = 1'b0;
    settle();
    check("w7_cleared", 64'(wf_instr_pending[7]), 0);
    check("w7_ready", 64'(decode_ready), 1);
    tick();
    idle();
    settle();
    check("w7_reacc", 64'(wf_instr_pending[7]), 1);
    check("w7_net", 64'(pending_count), 3);
    check("w7_wdata", 64'(decode_wr_data), 'h778);

    // Push while popping, then a full FIFO refusing while it pops.
    tick();
    offer(10, 'hA0);
    tick();
    offer(11, 'hB0);
    settle();
    check("pp_fwfid", 64'(f_decode_wfid), 10);
    check("pp_ready", 64'(decode_ready), 1);
    tick();
    idle();
    settle();
    check("pp_next_v", 64'(f_decode_valid), 1);
    check("pp_next_w", 64'(f_decode_wfid), 11);
    tick();
    tbl_wr_stall = 1'b1;
    offer(12, 'hC0);
    tick();
    offer(13, 'hD0);
    tick();
    tbl_wr_stall = 1'b0;
    offer(14, 'hE0);
    settle();
    check("full_pop_v", 64'(f_decode_valid), 1);
    check("full_pop_rdy", 64'(decode_ready), 0);
    tick();
    idle();
    tick(); tick(); settle();
    check("pp_count", 64'(pending_count), 7);

`ifdef DECODE_CAPTURE_FLUSH_EN
    issue_all();
    settle();
    check("fl_pre_count", 64'(pending_count), 0);
    tbl_wr_stall = 1'b1;
    offer(4, 'h444);
    tick();
    offer(9, 'h999);
    tick();
    idle();
    settle();
    check("fl_head4", 64'(f_decode_wfid), 4);
    check("fl_cnt2", 64'(pending_count), 2);
    flush_valid = 1'b1;
    flush_wfid  = `WF_ID_LENGTH'(4);
    settle();
    check("fl_sup", 64'(f_decode_valid), 0);
    tick();
    flush_valid = 1'b0;
    settle();
    check("fl_head9", 64'(f_decode_wfid), 9);
    check("fl_pend4", 64'(wf_instr_pending[4]), 0);
    check("fl_cnt1", 64'(pending_count), 1);
    tbl_wr_stall = 1'b0;
    settle();
    check("fl_wr9", 64'(f_decode_valid), 1);
    check("fl_data9", 64'(decode_wr_data), 'h999);
    tick(); settle();
    check("fl_empty", 64'(f_decode_valid), 0);
`endif

    // Fill every wavefront, then drain via issue.
    issue_all();
    settle();
    check("all_pre", 64'(pending_count), 0);
    for (int i = 0; i < `WF_PER_CU; i++) begin
      tick();
      offer(i, i + 'h100);
      settle();
      check($sformatf("all_rdy%0d", i), 64'(decode_ready), 1);
    end
    tick();
    idle();
    tick(); tick(); settle();
    check("all_count", 64'(pending_count), 40);
    check("all_pend", 64'(wf_instr_pending), 64'hFF_FFFF_FFFF);
    check("all_fvalid", 64'(f_decode_valid), 0);
    issue_all();
    settle();
    check("all_clr_cnt", 64'(pending_count), 0);
    check("all_clr_pend", 64'(wf_instr_pending), 0);

    // Reset mid-operation discards buffered entries.
    tbl_wr_stall = 1'b1;
    offer(20, 'h2020);
    tick();
    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tbl_wr_stall = 1'b0;
    settle();
    check("mid_rst_fv", 64'(f_decode_valid), 0);
    check("mid_rst_cnt", 64'(pending_count), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/decode_capture_stage.md
DECODE_CAPTURE_STAGE -- requirements
Module: decode_capture_stage

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset; synchronous, active-low (asserted when 0).
REQ-003 SHALL have port decode_valid, input, 1, decode presents an instruction this cycle.
REQ-004 SHALL have port decode_wfid, input, `WF_ID_LENGTH, wavefront of the presented instruction.
REQ-005 SHALL have port decode_instr_info, input, `ISSUE_INSTR_INFO_LENGTH, instruction info payload.
REQ-006 SHALL have port decode_ready, output, 1, stage accepts the presented instruction this cycle.
REQ-007 SHALL have port tbl_wr_stall, input, 1, info-table write port unavailable this cycle.
REQ-008 SHALL have port f_decode_valid, output, 1, info-table write strobe.
REQ-009 SHALL have port f_decode_wfid, output, `WF_ID_LENGTH, info-table write address.
REQ-010 SHALL have port decode_wr_data, output, `ISSUE_INSTR_INFO_LENGTH, info-table write data.
REQ-011 SHALL have port issue_valid, input, 1, issue consumed one instruction.
REQ-012 SHALL have port issue_wfid, input, `WF_ID_LENGTH, wavefront of issued instruction.
REQ-013 SHALL have port flush_valid / flush_wfid, input, 1 / `WF_ID_LENGTH, wavefront flush (only when DECODE_CAPTURE_FLUSH_EN defined).
REQ-014 SHALL have port wf_instr_pending, output, `WF_PER_CU, per-wavefront "instruction accepted, not yet issued" bit.
REQ-015 SHALL have port pending_count, output, 6, population count of wf_instr_pending.

Function
REQ-016 SHALL hold a 2-entry in-order FIFO of {wfid, instr_info}; entry 0 is head.
REQ-017 SHALL drive decode_ready = (occupancy < 2) AND NOT wf_instr_pending[decode_wfid], using registered state only.
REQ-018 SHALL accept (push) when decode_valid AND decode_ready; decode_valid with decode_ready low drops nothing, decode holds.
REQ-019 SHALL set wf_instr_pending[decode_wfid] on the clock edge of acceptance.
REQ-020 SHALL drive f_decode_valid = head valid AND NOT tbl_wr_stall; f_decode_wfid/decode_wr_data = head fields; pop on f_decode_valid.
REQ-021 SHALL give latency one cycle: instruction accepted at edge N appears on f_decode_* in cycle N+1 when FIFO was empty and no stall.
REQ-022 SHALL support push and pop in the same cycle (occupancy unchanged, order preserved); full FIFO does not accept even while popping.
REQ-023 SHALL clear wf_instr_pending[issue_wfid] on issue_valid; issue of a non-pending wfid is ignored.
REQ-024 SHALL, on issue clear and acceptance of the same wfid in one cycle, leave the bit clear and reject the decode (ready used registered bit).
REQ-025 SHALL maintain pending_count incrementally: +1 per accept, -1 per effective clear, net 0 when both; range 0..`WF_PER_CU.
REQ-026 SHALL keep f_decode_* outputs stable while tbl_wr_stall is high.

Reset
REQ-027 SHALL, while rst==0 at a clock edge, clear FIFO valids, wf_instr_pending, pending_count; f_decode_valid=0, f_decode_wfid=0, decode_wr_data=0, decode_ready=0 during reset.
REQ-028 SHALL discard in-flight FIFO entries on reset mid-operation; no write strobe in the first cycle after reset release.

Configuration
REQ-029 SHALL compile flush support only when DECODE_CAPTURE_FLUSH_EN is defined: flush_valid clears wf_instr_pending[flush_wfid], invalidates every FIFO entry with that wfid (entry 1 shifts to head if head invalidated), decrements pending_count, and suppresses f_decode_valid for a matching head that cycle; flush dominates same-cycle accept of that wfid.
REQ-030 SHALL, without DECODE_CAPTURE_FLUSH_EN, omit flush_valid/flush_wfid ports; pending bits clear only via issue.

Verification
REQ-031 Reset low 2 cycles with decode_valid=1 -> decode_ready=0, f_decode_valid=0, pending_count=0 throughout.
REQ-032 Accept wfid 5 info 0xABC, no stall -> next cycle f_decode_valid=1, f_decode_wfid=5, decode_wr_data=0xABC, wf_instr_pending[5]=1, pending_count=1.
REQ-033 tbl_wr_stall=1, accept wfids 1,2 -> decode_ready=0 on third offer (wfid 3); release stall -> writes wfid 1 then 2 in consecutive cycles.
REQ-034 wfid 7 pending, offer wfid 7 with issue_valid/issue_wfid=7 same cycle -> rejected; next cycle accepted, pending_count unchanged net.
REQ-035 FLUSH_EN, FIFO holds {4,9} stalled, flush wfid 4 -> head becomes wfid 9, pending[4]=0, pending_count decremented by 1.
REQ-036 Accept wfids 0..39 over time with no issue -> pending_count=40, all wf_instr_pending set; issue all -> count returns 0.
